rr_arbiter4: RTL and testbench

- Round-robin arbiter that shares one 32-bit datapath resource (memory/monitor bus port) among four requesters.
- The resource is fronted by the existing 4:1 32-bit select mux.
- Drives the mux's 2-bit select plus one-hot grants, and holds ownership until the resource signals completion.
- Sits between the requesting units (CPU data port, monitor/debug, DMA-style loaders) and the shared bus.

---
 rtl/rr_arbiter4_pkg.sv | 21 ++
 rtl/rr_arbiter4_pick4.sv | 32 +++
 rtl/rr_arbiter4.sv | 122 ++++++++++++
 tb/tb_rr_arbiter4.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/rr_arbiter4_pkg.sv
// Shared definitions for the four-way round-robin bus arbiter.
package rr_arbiter4_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    localparam logic [1:0] REQ_CPU = 2'd0;
    localparam logic [1:0] REQ_MON = 2'd1;
    localparam logic [1:0] REQ_LD  = 2'd2;
    localparam logic [1:0] REQ_AUX = 2'd3;

    localparam int ARB_TIMEOUT_DEF = 16;
    localparam int ARB_CNT_W_DEF   = 5;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_arbiter4_pick4.sv
// Combinational rotating-priority picker: search starts at last+1, so last is lowest priority.
// With excl_i set the requester at index last is removed from the candidates entirely.
module rr_pick4 (
    input  logic [3:0] req_i,
    input  logic [1:0] last_i,
    input  logic       excl_i,
    output logic [1:0] winner_o,
    output logic       any_o
);

    logic [3:0] cand;
    logic [1:0] idx;

    always_comb begin
        cand = req_i;
        if (excl_i) begin
            cand[last_i] = 1'b0;
        end
        idx      = '0;
        winner_o = last_i;
        // Walk from lowest to highest priority so the nearest candidate wins.
        for (int k = 4; k >= 1; k--) begin
            idx = last_i + 2'(k);
            if (cand[idx]) begin
                winner_o = idx;
            end
        end
    end

    assign any_o = |cand;

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter for one shared 32-bit resource, four requesters, registered grant/select.
// Define ARB_TIMEOUT_EN to force release of a grant held TIMEOUT cycles without done.
module rr_arbiter4
    import rr_arbiter4_pkg::*;
#(
    parameter int TIMEOUT = ARB_TIMEOUT_DEF,
    parameter int CNT_W   = ARB_CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       timeout
);

    arb_state_e state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] last_q, last_d;
    logic       busy_q, busy_d;
    logic       tmo_q, tmo_d;

    logic       in_grant, force_rel, rel_c, grant_ok, new_grant;
    logic       pick_any;
    logic [1:0] pick_win, win;

    assign in_grant = (state_q == ARB_GRANT);

    // In GRANT last_q is the current owner; it is excluded and only re-granted as a fallback.
    rr_pick4 u_pick (
        .req_i    (req),
        .last_i   (last_q),
        .excl_i   (in_grant),
        .winner_o (pick_win),
        .any_o    (pick_any)
    );

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign force_rel = in_grant && !done && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (new_grant) begin
            cnt_d = '0;
        end else if (in_grant) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{TIMEOUT[0], CNT_W[0]};
    assign force_rel  = 1'b0;
`endif

    assign rel_c     = in_grant && (done || !req[last_q] || force_rel);
    assign grant_ok  = pick_any || (in_grant && req[last_q]);
    assign win       = pick_any ? pick_win : last_q;
    assign new_grant = in_grant ? (rel_c && grant_ok) : pick_any;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            sel_q   <= REQ_CPU;
            last_q  <= REQ_AUX;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:  if (pick_any) state_d = ARB_GRANT;
            ARB_GRANT: if (rel_c && !grant_ok) state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        gnt_d  = gnt_q;
        sel_d  = sel_q;
        last_d = last_q;
        busy_d = busy_q;
        tmo_d  = force_rel;
        if (new_grant) begin
            gnt_d  = onehot4(win);
            sel_d  = win;
            last_d = win;
            busy_d = 1'b1;
        end else if (rel_c) begin
            // sel keeps pointing at the last owner while idle.
            gnt_d  = '0;
            busy_d = 1'b0;
        end
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign busy    = busy_q;
    assign timeout = tmo_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed vector bench for rr_arbiter4 plus hand-written timeout sequence.
module tb_rr_arbiter4;
    import rr_arbiter4_pkg::*;

    logic       clk = 1'b0;
    logic       rst, done;
    logic [3:0] req, gnt;
    logic [1:0] sel;
    logic       busy, timeout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rr_arbiter4 #(.TIMEOUT(4), .CNT_W(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .sel     (sel),
        .busy    (busy),
        .timeout (timeout)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       done;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       tmo;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [3:0] rq, input logic d,
                       input logic [3:0] g, input logic [1:0] s, input logic b);
        vec_t v;
        v.rst = r; v.req = rq; v.done = d; v.gnt = g; v.sel = s; v.busy = b; v.tmo = 1'b0;
        vecs.push_back(v);
    endtask

    task automatic step(input logic r, input logic [3:0] rq, input logic d);
        rst = r; req = rq; done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [3:0] eg, input logic [1:0] es,
                         input logic eb, input logic et);
        logic [3:0] oh;
        n_tests++;
        if (gnt !== eg || sel !== es || busy !== eb || timeout !== et) begin
            n_fail++;
            $display("FAIL %s: got gnt=%b sel=%0d busy=%b timeout=%b, want gnt=%b sel=%0d busy=%b timeout=%b",
                     nm, gnt, sel, busy, timeout, eg, es, eb, et);
        end
        oh = 4'b0001 << sel;
        n_tests++;
        if ($countones(gnt) > 1 || (busy && gnt !== oh) || (!busy && gnt !== 4'b0000)) begin
            n_fail++;
            $display("FAIL %s invariant: got gnt=%b sel=%0d busy=%b, want one-hot gnt matching sel when busy",
                     nm, gnt, sel, busy);
        end
    endtask

    initial begin
        rst = 1'b1; req = 4'b0000; done = 1'b0;

        // Reset, single request, release by done with the request dropped.
        add(1, 4'b0000, 0, 4'b0000, REQ_CPU, 0);
        add(0, 4'b0001, 0, 4'b0001, REQ_CPU, 1);
        add(0, 4'b0001, 0, 4'b0001, REQ_CPU, 1);
        add(0, 4'b0000, 1, 4'b0000, REQ_CPU, 0);
        add(0, 4'b0000, 1, 4'b0000, REQ_CPU, 0);
        // All requesting, done every third cycle: 0,1,2,3,0 without bubbles.
        add(1, 4'b0000, 0, 4'b0000, REQ_CPU, 0);
        add(0, 4'b1111, 0, 4'b0001, REQ_CPU, 1);
        add(0, 4'b1111, 0, 4'b0001, REQ_CPU, 1);
        add(0, 4'b1111, 1, 4'b0010, REQ_MON, 1);
        add(0, 4'b1111, 0, 4'b0010, REQ_MON, 1);
        add(0, 4'b1111, 0, 4'b0010, REQ_MON, 1);
        add(0, 4'b1111, 1, 4'b0100, REQ_LD, 1);
        add(0, 4'b1111, 0, 4'b0100, REQ_LD, 1);
        add(0, 4'b1111, 0, 4'b0100, REQ_LD, 1);
        add(0, 4'b1111, 1, 4'b1000, REQ_AUX, 1);
        add(0, 4'b1111, 0, 4'b1000, REQ_AUX, 1);
        add(0, 4'b1111, 0, 4'b1000, REQ_AUX, 1);
        add(0, 4'b1111, 1, 4'b0001, REQ_CPU, 1);
        // Owner 2 deprioritised: done while 1 and 2 request -> 1 wins.
        add(0, 4'b0100, 1, 4'b0100, REQ_LD, 1);
        add(0, 4'b0100, 0, 4'b0100, REQ_LD, 1);
        add(0, 4'b0110, 1, 4'b0010, REQ_MON, 1);
        add(0, 4'b0010, 0, 4'b0010, REQ_MON, 1);
        // Owner 1 abandons while 3 requests.
        add(0, 4'b1000, 0, 4'b1000, REQ_AUX, 1);
        add(0, 4'b1000, 0, 4'b1000, REQ_AUX, 1);
        add(0, 4'b0000, 0, 4'b0000, REQ_AUX, 0);
        add(0, 4'b0000, 0, 4'b0000, REQ_AUX, 0);
        // Lone owner still requesting is re-granted; then 0 beats owner 2.
        add(0, 4'b0100, 0, 4'b0100, REQ_LD, 1);
        add(0, 4'b0100, 1, 4'b0100, REQ_LD, 1);
        add(0, 4'b0101, 1, 4'b0001, REQ_CPU, 1);
        // Reset mid-grant, then fresh priority from requester 0.
        add(0, 4'b1111, 0, 4'b0001, REQ_CPU, 1);
        add(1, 4'b1111, 0, 4'b0000, REQ_CPU, 0);
        add(0, 4'b1111, 0, 4'b0001, REQ_CPU, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].req, vecs[i].done);
            check($sformatf("vec[%0d]", i), vecs[i].gnt, vecs[i].sel, vecs[i].busy, vecs[i].tmo);
        end

        // Hung owner: req=0011, done never asserted.
        step(1, 4'b0000, 0);
        check("tmo_reset", 4'b0000, REQ_CPU, 0, 0);
        step(0, 4'b0011, 0);
        check("tmo_grant0", 4'b0001, REQ_CPU, 1, 0);
`ifdef ARB_TIMEOUT_EN
        for (int c = 0; c < 3; c++) begin
            step(0, 4'b0011, 0);
            check($sformatf("tmo_hold[%0d]", c), 4'b0001, REQ_CPU, 1, 0);
        end
        step(0, 4'b0011, 0);
        check("tmo_forced", 4'b0010, REQ_MON, 1, 1);
        step(0, 4'b0011, 0);
        check("tmo_pulse_end", 4'b0010, REQ_MON, 1, 0);
`else
        for (int c = 0; c < 20; c++) begin
            step(0, 4'b0011, 0);
            check($sformatf("tmo_hold[%0d]", c), 4'b0001, REQ_CPU, 1, 0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
